gpzda_transmitter: RTL and testbench

Builds and emits a GPZDA NMEA sentence, one byte per handshake, from a UTC string and binary day/month/year values. It is the transmit-side counterpart of the GPZDA receive path. Its byte stream must parse in the `GpsReceiver` with `error` = 0 and identical field values. It sits between time-keeping logic and a byte-serial link (UART TX or loopback). Binary-to-ASCII decimal conversion is sequential, and the checksum is computed on the fly.

---
 rtl/gpzda_transmitter_if.sv | 12 +
 rtl/gpzda_transmitter.sv | 202 ++++++++++++++++++++
 tb/tb_gpzda_transmitter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpzda_transmitter_if.sv
// Byte stream carrying the transmitted GPZDA sentence: data/valid from the
// transmitter, ready back from the sink.
interface gpzda_transmitter_if #(
    parameter int B = 8
);
    logic [B-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/gpzda_transmitter.sv
// gpzda_transmitter: builds a "$GPZDA,..." NMEA sentence and sends it one byte per valid/ready transfer.
// Defining GPZDA_TX_CRLF_EN appends CR/LF after the checksum.
module gpzda_transmitter #(
    parameter int                     B         = 8,
    parameter int                     PrefixLen = 5,
    parameter logic [PrefixLen*B-1:0] Prefix    = "GPZDA",
    parameter logic [B-1:0]           Separator = ","
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [9*B-1:0]      utc,
    input  logic [2*B-1:0]      day,
    input  logic [2*B-1:0]      month,
    input  logic [2*B-1:0]      year,
    gpzda_transmitter_if.master tx,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int BaseLen = PrefixLen + 27;
`ifdef GPZDA_TX_CRLF_EN
    localparam int N = BaseLen + 2;
`else
    localparam int N = BaseLen;
`endif
    localparam logic [5:0] IdxLast = 6'(N - 1);
    localparam logic [5:0] IdxStar = 6'(BaseLen - 3);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_r;
    logic [9*B-1:0]   utc_r;
    logic [23:0]      day_dd_r;    // {2 BCD digits, binary shift register}
    logic [23:0]      month_dd_r;
    logic [31:0]      year_dd_r;   // {4 BCD digits, binary shift register}
    logic [3:0]       cnt_r;
    logic [5:0]       idx_r;
    logic [7:0]       cks_r;
    logic [B-1:0]     data_r;
    logic             valid_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;

    logic             out_of_range_s;
    logic [BaseLen*B-1:0] base_s;
    logic [N*B-1:0]   sentence_s;
    logic [B-1:0]     next_byte_s;

    // One double-dabble step for a 2-digit BCD field.
    function automatic logic [23:0] dabble2(input logic [23:0] v);
        logic [23:0] t;
        t = v;
        for (int i = 0; i < 2; i++) begin
            if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[22:0], 1'b0};
    endfunction

    // One double-dabble step for a 4-digit BCD field.
    function automatic logic [31:0] dabble4(input logic [31:0] v);
        logic [31:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[30:0], 1'b0};
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : ({4'h0, n} + 8'h37);
    endfunction

    // Range check on the raw start-cycle inputs.
    always_comb begin
        out_of_range_s = 1'b0;
        if ((day > 16'd99) || (month > 16'd99) || (year > 16'd9999)) begin
            out_of_range_s = 1'b1;
        end else begin
            out_of_range_s = 1'b0;
        end
    end

    // H/L read the live checksum; it is complete once the byte before "*" has gone out.
    assign base_s = {8'h24, Prefix, Separator, utc_r, Separator,
                     dec_char(day_dd_r[23:20]), dec_char(day_dd_r[19:16]), Separator,
                     dec_char(month_dd_r[23:20]), dec_char(month_dd_r[19:16]), Separator,
                     dec_char(year_dd_r[31:28]), dec_char(year_dd_r[27:24]),
                     dec_char(year_dd_r[23:20]), dec_char(year_dd_r[19:16]), Separator,
                     Separator, 8'h2A, hex_char(cks_r[7:4]), hex_char(cks_r[3:0])};

`ifdef GPZDA_TX_CRLF_EN
    assign sentence_s = {base_s, 8'h0D, 8'h0A};
`else
    assign sentence_s = base_s;
`endif

    // Byte mux: selects the byte following the one currently presented.
    always_comb begin
        next_byte_s = '0;
        if (idx_r < IdxLast) begin
            next_byte_s = sentence_s[(N - 2 - int'(idx_r)) * B +: B];
        end else begin
            next_byte_s = '0;
        end
    end

    // Sentence FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            utc_r      <= '0;
            day_dd_r   <= 24'h000000;
            month_dd_r <= 24'h000000;
            year_dd_r  <= 32'h00000000;
            cnt_r      <= 4'd0;
            idx_r      <= 6'd0;
            cks_r      <= 8'h00;
            data_r     <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (out_of_range_s) begin
                            error_r <= 1'b1;
                        end else begin
                            error_r    <= 1'b0;
                            busy_r     <= 1'b1;
                            utc_r      <= utc;
                            day_dd_r   <= {8'h00, day};
                            month_dd_r <= {8'h00, month};
                            year_dd_r  <= {16'h0000, year};
                            cnt_r      <= 4'd0;
                            idx_r      <= 6'd0;
                            cks_r      <= 8'h00;
                            state_r    <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    day_dd_r   <= dabble2(day_dd_r);
                    month_dd_r <= dabble2(month_dd_r);
                    year_dd_r  <= dabble4(year_dd_r);
                    cnt_r      <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        data_r  <= 8'h24;
                        valid_r <= 1'b1;
                        idx_r   <= 6'd0;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (valid_r && tx.ready) begin
                        if ((idx_r >= 6'd1) && (idx_r < IdxStar)) begin
                            cks_r <= cks_r ^ data_r;
                        end
                        if (idx_r == IdxLast) begin
                            valid_r <= 1'b0;
                            data_r  <= '0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            idx_r  <= idx_r + 6'd1;
                            data_r <= next_byte_s;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    idx_r   <= 6'd0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx.data  = data_r;
    assign tx.valid = valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign error    = error_r;

endmodule

// File: tb/tb_gpzda_transmitter.sv
// Self-checking bench for gpzda_transmitter: randomized fields and ready pattern
// compared against a sentence model built from the NMEA field rules.
module tb_gpzda_transmitter;

`ifdef GPZDA_TX_CRLF_EN
    localparam int N = 34;
`else
    localparam int N = 32;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [71:0] utc;
    logic [15:0] day;
    logic [15:0] month;
    logic [15:0] year;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    gpzda_transmitter_if #(.B(8)) tx_if ();

    gpzda_transmitter dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .utc   (utc),
        .day   (day),
        .month (month),
        .year  (year),
        .tx    (tx_if),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dc(input int v);
        return 8'(48 + v);
    endfunction

    function automatic logic [7:0] hx(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    function automatic logic [71:0] rand_utc();
        int h, m, s, f;
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 59);
        s = $urandom_range(0, 59);
        f = $urandom_range(0, 99);
        return {dc(h / 10), dc(h % 10), dc(m / 10), dc(m % 10), dc(s / 10), dc(s % 10),
                8'h2E, dc(f / 10), dc(f % 10)};
    endfunction

    // Reference sentence from the field rules: decimal fields, XOR of bytes between '$' and '*'.
    task automatic build_expected(input logic [71:0] u, input int d, input int m, input int y);
        string      p;
        logic [7:0] cs;
        p  = "GPZDA";
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'h24);
        for (int i = 0; i < p.len(); i++) exp_q.push_back(p[i]);
        exp_q.push_back(8'h2C);
        for (int i = 0; i < 9; i++) exp_q.push_back(u[71 - 8*i -: 8]);
        exp_q.push_back(8'h2C);
        exp_q.push_back(dc(d / 10));
        exp_q.push_back(dc(d % 10));
        exp_q.push_back(8'h2C);
        exp_q.push_back(dc(m / 10));
        exp_q.push_back(dc(m % 10));
        exp_q.push_back(8'h2C);
        exp_q.push_back(dc(y / 1000));
        exp_q.push_back(dc((y / 100) % 10));
        exp_q.push_back(dc((y / 10) % 10));
        exp_q.push_back(dc(y % 10));
        exp_q.push_back(8'h2C);
        exp_q.push_back(8'h2C);
        for (int i = 1; i < exp_q.size(); i++) cs = cs ^ exp_q[i];
        exp_q.push_back(8'h2A);
        exp_q.push_back(hx(int'(cs[7:4])));
        exp_q.push_back(hx(int'(cs[3:0])));
`ifdef GPZDA_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Runs one sentence from the current negedge; abort_at >= 0 pulses reset at that byte.
    task automatic run_sentence(input logic [71:0] u, input int d, input int m, input int y,
                                input bit rand_ready, input bit hold_start, input int abort_at);
        int         got;
        int         first_j;
        int         done_j;
        int         low_j;
        bit         stalled;
        logic [7:0] held;
        got     = 0;
        first_j = -1;
        done_j  = -1;
        low_j   = -1;
        stalled = 1'b0;
        held    = 8'h00;
        build_expected(u, d, m, y);
        utc   = u;
        day   = 16'(d);
        month = 16'(m);
        year  = 16'(y);
        start = 1'b1;
        @(posedge clock);
        for (int j = 0; j < 400 && low_j < 0; j++) begin
            @(negedge clock);
            if (j == 0) begin
                check_eq("busy_rise", busy, 1);
                check_eq("error_clear", error, 0);
                if (!hold_start) begin
                    start = 1'b0;
                    utc   = rand_utc();
                    day   = 16'($urandom_range(0, 200));
                    month = 16'($urandom_range(0, 200));
                    year  = 16'($urandom_range(0, 20000));
                end
            end
            if (stalled) begin
                check_eq("hold_valid", tx_if.valid, 1);
                check_eq("hold_data", tx_if.data, held);
            end
            if (tx_if.valid && first_j < 0) first_j = j;
            if (done && done_j < 0) done_j = j;
            if (!busy) begin
                low_j = j;
                check_eq("done_fall", done, 0);
            end
            if (abort_at >= 0 && tx_if.valid && got == abort_at) begin
                reset = 1'b1;
                #1;
                check_eq("abort_valid", tx_if.valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_data", tx_if.data, 0);
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            tx_if.ready = rand_ready ? 1'($urandom_range(0, 9) < 6) : 1'b1;
            if (tx_if.valid && tx_if.ready) begin
                if (got < exp_q.size()) check_eq("byte", tx_if.data, exp_q[got]);
                else check_eq("extra_byte", got, exp_q.size());
                got++;
            end
            stalled = tx_if.valid && !tx_if.ready;
            held    = tx_if.data;
        end
        check_eq("busy_fall_seen", (low_j >= 0), 1);
        check_eq("byte_count", got, N);
        if (!rand_ready) begin
            check_eq("first_valid_lat", first_j, 16);
            check_eq("done_lat", done_j, 16 + N);
            check_eq("idle_lat", low_j, 17 + N);
        end else begin
            check_eq("done_to_idle", low_j - done_j, 1);
        end
    endtask

    // Out-of-range request: expect error and no activity.
    task automatic reject(input int d, input int m, input int y);
        logic exp_err;
        exp_err = (d > 99) || (m > 99) || (y > 9999);
        utc   = rand_utc();
        day   = 16'(d);
        month = 16'(m);
        year  = 16'(y);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check_eq("err_set", error, exp_err);
        for (int i = 0; i < 4; i++) begin
            check_eq("err_valid", tx_if.valid, 0);
            check_eq("err_busy", busy, 0);
            @(negedge clock);
        end
        check_eq("err_hold", error, exp_err);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        utc         = '0;
        day         = '0;
        month       = '0;
        year        = '0;
        tx_if.ready = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_data", tx_if.data, 0);
        check_eq("rst_valid", tx_if.valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        reset = 1'b0;
        @(negedge clock);

        run_sentence("123519.00", 11, 6, 2024, 1'b0, 1'b0, -1);
        run_sentence(rand_utc(), 1, 1, 0, 1'b0, 1'b0, -1);
        run_sentence("123519.00", 11, 6, 2024, 1'b1, 1'b0, -1);

        reject(11, 6, 10000);
        reject(100, 6, 2024);
        reject(11, 100, 2024);
        run_sentence("235959.99", 99, 99, 9999, 1'b0, 1'b0, -1);

        run_sentence(rand_utc(), 11, 6, 2024, 1'b0, 1'b0, 15);
        run_sentence("123519.00", 11, 6, 2024, 1'b0, 1'b0, -1);

        for (int i = 0; i < 3; i++) begin
            run_sentence(rand_utc(), $urandom_range(0, 99), $urandom_range(0, 99),
                         $urandom_range(0, 9999), 1'b0, 1'b1, -1);
        end
        start = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_sentence(rand_utc(), $urandom_range(0, 99), $urandom_range(0, 99),
                         $urandom_range(0, 9999), 1'b1, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
